// File: rtl/systolic_feeder.sv
// Operand loader, skewed wavefront driver and result unloader for a 3x3 output-stationary systolic array.
// Latency: out_valid rises DRAIN_CYCLES+7 cycles after the 18th operand handshake (cycle L+10 at default).
// Backpressure: in_ready only in LOAD; out_ready low holds out_data/k indefinitely. Optional macro: SYSTOLIC_RELU_EN.
module systolic_feeder #(
  parameter int data_size    = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_size-1:0] in_data,
  output logic [data_size-1:0] a1,
  output logic [data_size-1:0] a2,
  output logic [data_size-1:0] a3,
  output logic [data_size-1:0] b1,
  output logic [data_size-1:0] b2,
  output logic [data_size-1:0] b3,
  output logic                 arr_clr,
  input  logic [data_size-1:0] c1,
  input  logic [data_size-1:0] c2,
  input  logic [data_size-1:0] c3,
  input  logic [data_size-1:0] c4,
  input  logic [data_size-1:0] c5,
  input  logic [data_size-1:0] c6,
  input  logic [data_size-1:0] c7,
  input  logic [data_size-1:0] c8,
  input  logic [data_size-1:0] c9,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  // Drain counter sized to hold DRAIN_CYCLES-1 (at least one bit).
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [4:0]     n;        // operand slot being loaded, 0..17
  logic [2:0]     t;        // wavefront index, 0..4
  logic [3:0]     k;        // result word being offered, 0..8
  logic [DCW-1:0] dcnt;     // drain cycle index
  logic           load_en;  // holds in_ready low while rst is asserted

  logic [data_size-1:0] opnd   [18];
  logic [data_size-1:0] result [9];
  logic [data_size-1:0] c_vec  [9];
  logic [data_size-1:0] cap    [9];

  logic in_hs, out_hs;
  logic load_last, feed_last, drain_last, out_lastw;

  assign in_hs      = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready;
  assign load_last  = (n == 5'd17);
  assign feed_last  = (t == 3'd4);
  assign drain_last = (dcnt == DLAST);
  assign out_lastw  = (k == 4'd8);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && load_last) state_nxt = CLR;
      CLR:     state_nxt = FEED;
      FEED:    if (feed_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = OUT;
      OUT:     if (out_hs && out_lastw) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Slot, wavefront, drain and result counters; each wraps to 0 as its phase ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n    <= '0;
      t    <= '0;
      k    <= '0;
      dcnt <= '0;
    end else begin
      if (state == LOAD && in_hs) n <= load_last ? 5'd0 : n + 5'd1;
      if (state == FEED) t <= feed_last ? 3'd0 : t + 3'd1;
      if (state == DRAIN) dcnt <= drain_last ? '0 : dcnt + 1'b1;
      if (state == OUT && out_hs) k <= out_lastw ? 4'd0 : k + 4'd1;
    end
  end

  // in_ready stays low during reset and rises the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_en <= 1'b0;
    else     load_en <= 1'b1;
  end

  // Operand store: every operation overwrites all 18 slots, so no clear is needed.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_hs) opnd[n] <= in_data;
  end

  // Flatten array results into PE order (row-major).
  always_comb begin
    c_vec[0] = c1;
    c_vec[1] = c2;
    c_vec[2] = c3;
    c_vec[3] = c4;
    c_vec[4] = c5;
    c_vec[5] = c6;
    c_vec[6] = c7;
    c_vec[7] = c8;
    c_vec[8] = c9;
  end

  // Capture transform: optional clamp of negative results to zero.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
`ifdef SYSTOLIC_RELU_EN
      cap[i] = c_vec[i][data_size-1] ? '0 : c_vec[i];
`else
      cap[i] = c_vec[i];
`endif
    end
  end

  // Result store, written once on the final drain edge.
  always_ff @(posedge clk) begin
    if (state == DRAIN && drain_last) begin
      for (int i = 0; i < 9; i++) result[i] <= cap[i];
    end
  end

  // Skewed wavefronts: row i carries A[i][t-i], column j carries B[t-j][j].
  // Slots: A[i][j] = opnd[3i+j], B[i][j] = opnd[9+3i+j].
  always_comb begin
    a1 = '0;
    a2 = '0;
    a3 = '0;
    b1 = '0;
    b2 = '0;
    b3 = '0;
    if (state == FEED) begin
      case (t)
        3'd0: begin
          a1 = opnd[0];                    // A00
          b1 = opnd[9];                    // B00
        end
        3'd1: begin
          a1 = opnd[1];  a2 = opnd[3];     // A01 A10
          b1 = opnd[12]; b2 = opnd[10];    // B10 B01
        end
        3'd2: begin
          a1 = opnd[2];  a2 = opnd[4];  a3 = opnd[6];   // A02 A11 A20
          b1 = opnd[15]; b2 = opnd[13]; b3 = opnd[11];  // B20 B11 B02
        end
        3'd3: begin
          a2 = opnd[5];  a3 = opnd[7];     // A12 A21
          b2 = opnd[16]; b3 = opnd[14];    // B21 B12
        end
        3'd4: begin
          a3 = opnd[8];                    // A22
          b3 = opnd[17];                   // B22
        end
        default: begin
          a1 = '0;
        end
      endcase
    end
  end

  // Control and result outputs decode from registered state only.
  always_comb begin
    in_ready  = load_en && (state == LOAD);
    arr_clr   = (state == CLR);
    busy      = (state != LOAD);
    out_valid = (state == OUT);
    out_last  = (state == OUT) && out_lastw;
    out_data  = (state == OUT) ? result[k] : '0;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 3x3 output-stationary array attached.
// Expected results are hand-computed matrix products.
// Exercises latency, skew, back-to-back, backpressure, mid-operation reset and sign handling.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [31:0] a1, a2, a3, b1, b2, b3;
  logic        arr_clr;
  logic [31:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
  logic        out_valid, out_ready, out_last, busy;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_cnt = 0;

  systolic_feeder #(.data_size(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .arr_clr(arr_clr),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8), .c9(c9),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (arr_clr === 1'b1) clr_cnt++;

  // Behavioural array: PEs forward a right and b down, accumulate a*b each cycle.
  logic [31:0] pa [9];
  logic [31:0] pb [9];
  logic [31:0] acc [9];
  logic [31:0] a_edge [3];
  logic [31:0] b_edge [3];
  assign a_edge[0] = a1; assign a_edge[1] = a2; assign a_edge[2] = a3;
  assign b_edge[0] = b1; assign b_edge[1] = b2; assign b_edge[2] = b3;

  // Array state update, cleared by rst or arr_clr.
  always @(posedge clk or posedge rst) begin
    if (rst || arr_clr) begin
      for (int i = 0; i < 9; i++) begin
        pa[i] <= '0; pb[i] <= '0; acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          logic [31:0] ai, bi;
          ai = (j == 0) ? a_edge[i] : pa[3*i+j-1];
          bi = (i == 0) ? b_edge[j] : pb[3*(i-1)+j];
          acc[3*i+j] <= acc[3*i+j] + ai * bi;
          pa[3*i+j]  <= ai;
          pb[3*i+j]  <= bi;
        end
      end
    end
  end

  assign c1 = acc[0]; assign c2 = acc[1]; assign c3 = acc[2];
  assign c4 = acc[3]; assign c5 = acc[4]; assign c6 = acc[5];
  assign c7 = acc[6]; assign c8 = acc[7]; assign c9 = acc[8];

  logic [31:0] m_id   [9];
  logic [31:0] m_seq  [9];
  logic [31:0] m_two  [9];
  logic [31:0] m_neg  [9];
  logic [31:0] r_seq2 [9];
  logic [31:0] r_12   [9];
  logic [31:0] r_neg  [9];

  // Present 18 operand words; returns the cycle number of the final handshake.
  task automatic load_op(input logic [31:0] am [9], input logic [31:0] bm [9],
                         input bit gaps, output int hs_cyc);
    int budget;
    hs_cyc = 0;
    for (int n = 0; n < 18; n++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (n < 9) ? am[n] : bm[n-9];
      budget = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (in_ready !== 1'b1) begin
        checks++; errors++;
        $display("FAIL load_timeout slot %0d in_ready=%b required 1", n, in_ready);
      end
      hs_cyc = cyc;
    end
  endtask

  // Drain nine results, checking data, last flag, stability under stall and in_ready low.
  task automatic unload_op(input logic [31:0] exp [9], input bit stall, output int first_cyc);
    int kk, budget;
    bit held, seen, tog;
    logic [31:0] hv;
    kk = 0; budget = 0; held = 0; seen = 0; tog = 0; hv = '0; first_cyc = 0;
    while (kk < 9 && budget < 300) begin
      @(negedge clk);
      budget++;
      in_valid  = 1'b0;
      out_ready = stall ? tog : 1'b1;
      tog = !tog;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_busy cyc %0d got %b required 0", cyc, in_ready);
      end
      if (out_valid === 1'b1) begin
        if (!seen) first_cyc = cyc;
        seen = 1;
        if (held) begin
          checks++;
          if (out_data !== hv) begin
            errors++;
            $display("FAIL stall_stable got %h required %h", out_data, hv);
          end
        end
        if (out_ready) begin
          checks++;
          if (out_data !== exp[kk]) begin
            errors++;
            $display("FAIL out_data[%0d] got %h required %h", kk, out_data, exp[kk]);
          end
          checks++;
          if (out_last !== (kk == 8)) begin
            errors++;
            $display("FAIL out_last[%0d] got %b required %b", kk, out_last, (kk == 8));
          end
          kk++;
          held = 0;
        end else begin
          held = 1;
          hv = out_data;
        end
      end
    end
    if (kk < 9) begin
      checks++; errors++;
      $display("FAIL unload_timeout got %0d words required 9", kk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL return_load in_ready=%b out_valid=%b busy=%b required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, busy, arr_clr} !== 5'b0 || out_data !== 32'd0 ||
        {a1, a2, a3, b1, b2, b3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b busy=%b arr_clr=%b required all 0",
               in_ready, out_valid, busy, arr_clr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_identity();
    int hs, fc, c0;
    c0 = clr_cnt;
    load_op(m_id, m_seq, 0, hs);
    unload_op(m_seq, 0, fc);
    checks++;
    if (fc - hs !== 10) begin
      errors++;
      $display("FAIL latency got %0d required 10", fc - hs);
    end
    checks++;
    if (clr_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL arr_clr_identity got %0d required 1", clr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    int hs, fc, c0;
    c0 = clr_cnt;
    load_op(m_seq, m_seq, 0, hs);
    unload_op(r_seq2, 0, fc);
    checks++;
    if (clr_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL arr_clr_op1 got %0d required 1", clr_cnt - c0);
    end
    c0 = clr_cnt;
    load_op(m_two, m_two, 0, hs);
    unload_op(r_12, 0, fc);
    checks++;
    if (clr_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL arr_clr_op2 got %0d required 1", clr_cnt - c0);
    end
  endtask

  task automatic test_backpressure();
    int hs, fc;
    load_op(m_seq, m_seq, 1, hs);
    unload_op(r_seq2, 1, fc);
  endtask

  task automatic test_reset_mid_feed();
    int hs, fc;
    load_op(m_id, m_seq, 0, hs);
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    // Cycle L+4 is FEED t=2: A02 A11 A20 / B20 B11 B02.
    checks++;
    if (a1 !== 32'd0 || a2 !== 32'd1 || a3 !== 32'd0) begin
      errors++;
      $display("FAIL feed_t2_a got %0d %0d %0d required 0 1 0", a1, a2, a3);
    end
    checks++;
    if (b1 !== 32'd7 || b2 !== 32'd5 || b3 !== 32'd3) begin
      errors++;
      $display("FAIL feed_t2_b got %0d %0d %0d required 7 5 3", b1, b2, b3);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, busy, arr_clr} !== 5'b0 || out_data !== 32'd0 ||
        {a1, a2, a3, b1, b2, b3} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs in_ready=%b out_valid=%b busy=%b a1=%0d a2=%0d b1=%0d required all 0",
               in_ready, out_valid, busy, a1, a2, b1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    load_op(m_id, m_seq, 0, hs);
    unload_op(m_seq, 0, fc);
  endtask

  task automatic test_sign();
    int hs, fc;
    load_op(m_neg, m_id, 0, hs);
    unload_op(r_neg, 0, fc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_id  = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    m_seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    m_two = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    m_neg = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
    r_seq2 = '{32'd30, 32'd36, 32'd42, 32'd66, 32'd81, 32'd96, 32'd102, 32'd126, 32'd150};
    r_12   = '{32'd12, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12};
`ifdef SYSTOLIC_RELU_EN
    r_neg  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`else
    r_neg  = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
`endif
    test_reset();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_feed();
    test_sign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
